// File: rtl/tribuf_bus_arbiter_pkg.sv
// Shared definitions for the tri-state bus arbiter: FSM state encoding
// and the round-robin index helper used by the priority picker.
package tribuf_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        STATE_IDLE  = 2'd0,
        STATE_GRANT = 2'd1,
        STATE_TURN  = 2'd2
    } state_t;

    // Index reached by stepping 'offset' places above 'base', wrapping modulo n.
    function automatic int unsigned rr_index(input int unsigned base,
                                             input int unsigned offset,
                                             input int unsigned n);
        return (base + offset) % n;
    endfunction

endpackage

// File: rtl/tribuf_bus_arbiter_rr_priority_pick.sv
// Combinational round-robin picker: searches req upward from ptr+1,
// wrapping, so the requester at ptr itself has the lowest priority.
module rr_priority_pick
    import tribuf_bus_arbiter_pkg::*;
#(
    parameter int NUM_REQS = 4,
    parameter int IDX_SZ   = 2
) (
    input  logic [NUM_REQS-1:0] req,
    input  logic [IDX_SZ-1:0]   ptr,
    output logic [NUM_REQS-1:0] winner_oh,
    output logic [IDX_SZ-1:0]   winner_idx,
    output logic                any
);

    // Scan from lowest to highest priority so the last hit is the winner.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch.
        winner_oh  = '0;
        winner_idx = '0;
        any        = |req;
        for (int k = NUM_REQS; k >= 1; k--) begin
            logic [IDX_SZ-1:0] cand;
            cand = IDX_SZ'(rr_index(32'(ptr), k, NUM_REQS));
            if (req[cand]) begin
                winner_idx = cand;
            end
        end
        if (any) begin
            winner_oh[winner_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/tribuf_bus_arbiter.sv
// Round-robin owner scheduler driving the per-partition output enables
// of a shared tri-state bus. A tenure ends on done_p, on the owner
// dropping its request, or after MAX_HOLD cycles.
// Build option: define TRIBUF_BUS_ARBITER_TURNAROUND_EN to insert one
// undriven cycle between owners; otherwise ownership hands off directly.
module tribuf_bus_arbiter
    import tribuf_bus_arbiter_pkg::*;
#(
    parameter int NUM_REQS = 4,
    parameter int MAX_HOLD = 8,
    parameter int IDX_SZ   = 2,
    parameter int HOLD_SZ  = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_REQS-1:0] req,
    input  logic                done_p,
    output logic [NUM_REQS-1:0] oe,
    output logic                grant_val,
    output logic [IDX_SZ-1:0]   grant_idx,
    output logic                release_p
);

    localparam logic [HOLD_SZ-1:0] HOLD_LAST = HOLD_SZ'(MAX_HOLD - 1);

    state_t              state;
    logic [IDX_SZ-1:0]   ptr;
    logic [HOLD_SZ-1:0]  hold_cnt;
    logic [NUM_REQS-1:0] win_oh;
    logic [IDX_SZ-1:0]   win_idx;
    logic                win_any;
    logic                timeout;

    // ptr always holds the current (or most recent) owner, so a pick made at
    // release time automatically puts that owner last in line.
    rr_priority_pick #(
        .NUM_REQS (NUM_REQS),
        .IDX_SZ   (IDX_SZ)
    ) u_pick (
        .req        (req),
        .ptr        (ptr),
        .winner_oh  (win_oh),
        .winner_idx (win_idx),
        .any        (win_any)
    );

    assign timeout   = (hold_cnt == HOLD_LAST);
    assign release_p = (state == STATE_GRANT) && (done_p || !req[grant_idx] || timeout);

    // Ownership FSM with registered enables; reset clears oe without a clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= STATE_IDLE;
            oe        <= '0;
            grant_val <= 1'b0;
            grant_idx <= '0;
            hold_cnt  <= '0;
            ptr       <= IDX_SZ'(NUM_REQS - 1);
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            case (state)
                STATE_IDLE: begin
                    if (win_any) begin
                        state     <= STATE_GRANT;
                        oe        <= win_oh;
                        grant_val <= 1'b1;
                        grant_idx <= win_idx;
                        ptr       <= win_idx;
                        hold_cnt  <= '0;
                    end
                end

                STATE_GRANT: begin
                    if (release_p) begin
`ifdef TRIBUF_BUS_ARBITER_TURNAROUND_EN
                        state     <= STATE_TURN;
                        oe        <= '0;
                        grant_val <= 1'b0;
                        grant_idx <= '0;
                        hold_cnt  <= '0;
`else
                        if (win_any) begin
                            oe        <= win_oh;
                            grant_val <= 1'b1;
                            grant_idx <= win_idx;
                            ptr       <= win_idx;
                            hold_cnt  <= '0;
                        end else begin
                            state     <= STATE_IDLE;
                            oe        <= '0;
                            grant_val <= 1'b0;
                            grant_idx <= '0;
                            hold_cnt  <= '0;
                        end
`endif
                    end else if (!timeout) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end

                STATE_TURN: begin
                    if (win_any) begin
                        state     <= STATE_GRANT;
                        oe        <= win_oh;
                        grant_val <= 1'b1;
                        grant_idx <= win_idx;
                        ptr       <= win_idx;
                        hold_cnt  <= '0;
                    end else begin
                        state <= STATE_IDLE;
                    end
                end

                default: begin
                    state     <= STATE_IDLE;
                    oe        <= '0;
                    grant_val <= 1'b0;
                    grant_idx <= '0;
                    hold_cnt  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tribuf_bus_arbiter.sv
// Scoreboard bench for tribuf_bus_arbiter (NUM_REQS=4, MAX_HOLD=8).
// Stimulus pushes the expected per-cycle outputs; a negedge monitor pops
// and compares them. Vectors follow the default build; the handoff
// vectors switch when TRIBUF_BUS_ARBITER_TURNAROUND_EN is defined.
module tb_tribuf_bus_arbiter;

    logic       clk;
    logic       reset;
    logic [3:0] req;
    logic       done_p;
    logic [3:0] oe;
    logic       grant_val;
    logic [1:0] grant_idx;
    logic       release_p;

    typedef struct {
        logic [3:0] oe;
        logic       rel;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    tribuf_bus_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .done_p    (done_p),
        .oe        (oe),
        .grant_val (grant_val),
        .grant_idx (grant_idx),
        .release_p (release_p)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] idx_of(input logic [3:0] v);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (v[i]) r = 2'(i);
        end
        return r;
    endfunction

    // Drive one cycle of inputs and record the outputs expected in that cycle.
    task automatic step(input logic [3:0] r, input logic d, input logic rs,
                        input logic [3:0] eoe, input logic erel, input string nm);
        @(posedge clk);
        #1;
        req    = r;
        done_p = d;
        reset  = rs;
        exp_q.push_back('{oe: eoe, rel: erel, name: nm});
    endtask

    // Monitor: compare DUT outputs against the next scoreboard entry.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check({e.name, ".oe"},        32'(oe),               32'(e.oe));
            check({e.name, ".grant_val"}, 32'(grant_val),        32'(|e.oe));
            check({e.name, ".grant_idx"}, 32'(grant_idx),        32'(idx_of(e.oe)));
            check({e.name, ".release_p"}, 32'(release_p),        32'(e.rel));
            check({e.name, ".onehot0"},   32'($countones(oe) <= 1), 32'(1));
        end
    end

    initial begin
        clk    = 1'b0;
        reset  = 1'b0;
        req    = 4'b0000;
        done_p = 1'b0;
        #1 reset = 1'b1;

        // Reset state, then done_p while idle is ignored.
        step(4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, "rst0");
        step(4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, "rst1");
        step(4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, "idle_done0");
        step(4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, "idle_done1");

`ifdef TRIBUF_BUS_ARBITER_TURNAROUND_EN
        // Handoff 0 -> 1 with one undriven cycle in between.
        step(4'b0011, 1'b0, 1'b0, 4'b0000, 1'b0, "ta0");
        step(4'b0011, 1'b1, 1'b0, 4'b0001, 1'b1, "ta_own0");
        step(4'b0011, 1'b0, 1'b0, 4'b0000, 1'b0, "ta_turn");
        step(4'b0011, 1'b0, 1'b0, 4'b0010, 1'b0, "ta_own1");
        step(4'b0000, 1'b0, 1'b0, 4'b0010, 1'b1, "ta_rel");
        step(4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, "ta_turn2");
        step(4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, "ta_idle");
`else
        // Round-robin with done_p every cycle: owners 0,1,2,3,0 back to back.
        step(4'b1111, 1'b0, 1'b0, 4'b0000, 1'b0, "rr0");
        step(4'b1111, 1'b1, 1'b0, 4'b0001, 1'b1, "rr1");
        step(4'b1111, 1'b1, 1'b0, 4'b0010, 1'b1, "rr2");
        step(4'b1111, 1'b1, 1'b0, 4'b0100, 1'b1, "rr3");
        step(4'b1111, 1'b1, 1'b0, 4'b1000, 1'b1, "rr4");
        step(4'b1111, 1'b1, 1'b0, 4'b0001, 1'b1, "rr5");
        step(4'b0000, 1'b0, 1'b0, 4'b0010, 1'b1, "rr6");
        step(4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, "rr7");

        // Timeout of a sole requester: 8 cycles, release on the 8th, re-grant.
        step(4'b0001, 1'b0, 1'b0, 4'b0000, 1'b0, "to0");
        for (int i = 0; i < 7; i++) begin
            step(4'b0001, 1'b0, 1'b0, 4'b0001, 1'b0, "to_hold");
        end
        step(4'b0001, 1'b0, 1'b0, 4'b0001, 1'b1, "to_last");
        step(4'b0001, 1'b0, 1'b0, 4'b0001, 1'b0, "to_regrant");
        step(4'b0000, 1'b0, 1'b0, 4'b0001, 1'b1, "to_drop");
        step(4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, "to_idle");

        // Preemption: owner 0 times out (with done_p) -> 1; req[0] drop releases.
        step(4'b0001, 1'b0, 1'b0, 4'b0000, 1'b0, "pre0");
        for (int i = 0; i < 7; i++) begin
            step(4'b0011, 1'b0, 1'b0, 4'b0001, 1'b0, "pre_hold");
        end
        step(4'b0011, 1'b1, 1'b0, 4'b0001, 1'b1, "pre_last");
        step(4'b0011, 1'b0, 1'b0, 4'b0010, 1'b0, "pre_next");
        step(4'b0011, 1'b1, 1'b0, 4'b0010, 1'b1, "pre_done");
        step(4'b0011, 1'b0, 1'b0, 4'b0001, 1'b0, "pre_back");
        step(4'b0010, 1'b0, 1'b0, 4'b0001, 1'b1, "pre_drop");
        step(4'b0010, 1'b0, 1'b0, 4'b0010, 1'b0, "pre_hand");
        step(4'b0000, 1'b0, 1'b0, 4'b0010, 1'b1, "pre_rel");
        step(4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, "pre_idle");
`endif

        // Reset mid-tenure: oe clears before any clock edge; re-grant after release.
        step(4'b0010, 1'b0, 1'b0, 4'b0000, 1'b0, "rm0");
        step(4'b0010, 1'b0, 1'b0, 4'b0010, 1'b0, "rm_grant");
        step(4'b0010, 1'b0, 1'b0, 4'b0010, 1'b0, "rm_hold");
        step(4'b0010, 1'b0, 1'b1, 4'b0000, 1'b0, "rm_assert");
        #1;
        check("rm_async.oe",        32'(oe),        32'(0));
        check("rm_async.grant_val", 32'(grant_val), 32'(0));
        step(4'b0010, 1'b0, 1'b1, 4'b0000, 1'b0, "rm_held");
        step(4'b0010, 1'b0, 1'b0, 4'b0000, 1'b0, "rm_release");
        step(4'b0010, 1'b0, 1'b0, 4'b0010, 1'b0, "rm_regrant");
        step(4'b0000, 1'b0, 1'b0, 4'b0010, 1'b1, "rm_drop");
        step(4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, "rm_idle");

        // Let the monitor drain the scoreboard, bounded.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(negedge clk);
        end
        #1;
        check("drain.pending", 32'(exp_q.size()), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
